// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squashing and
// a saturating count of inserted bubbles for the debug unit.
module id_ex_stage #(
   parameter int EXEC_BUS_WIDTH = 7,
   parameter int MEM_BUS_WIDTH  = 3,
   parameter int WB_BUS_WIDTH   = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int PC_WIDTH       = 32,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      flush,
   input  logic [EXEC_BUS_WIDTH-1:0] id_execute_bus,
   input  logic [MEM_BUS_WIDTH-1:0]  id_memory_bus,
   input  logic [WB_BUS_WIDTH-1:0]   id_wb_bus,
   input  logic [31:0]               id_instruction,
   input  logic [PC_WIDTH-1:0]       id_pc_next,
   input  logic [DATA_WIDTH-1:0]     id_rs_data,
   input  logic [DATA_WIDTH-1:0]     id_rt_data,
   output logic [EXEC_BUS_WIDTH-1:0] ex_execute_bus,
   output logic [MEM_BUS_WIDTH-1:0]  ex_memory_bus,
   output logic [WB_BUS_WIDTH-1:0]   ex_wb_bus,
   output logic [PC_WIDTH-1:0]       ex_pc_next,
   output logic [DATA_WIDTH-1:0]     ex_rs_data,
   output logic [DATA_WIDTH-1:0]     ex_rt_data,
   output logic [DATA_WIDTH-1:0]     ex_imm,
   output logic [4:0]                ex_rs,
   output logic [4:0]                ex_rt,
   output logic [4:0]                ex_rd,
   output logic [4:0]                ex_shamt,
   output logic                      ex_valid,
   output logic                      hazard_stall,
   output logic                      pc_write,
   output logic                      if_id_write,
   output logic [CNT_WIDTH-1:0]      bubble_count
);

   localparam logic [3:0] ZEXT_OPCODE_HI = 4'b0011;
   localparam int         MEM_READ_BIT   = 1;

   logic [EXEC_BUS_WIDTH-1:0] exec_reg, exec_next, exec_gated;
   logic [MEM_BUS_WIDTH-1:0]  mem_reg, mem_next, mem_gated;
   logic [WB_BUS_WIDTH-1:0]   wb_reg, wb_next, wb_gated;
   logic [PC_WIDTH-1:0]       pc_reg, pc_next;
   logic [DATA_WIDTH-1:0]     rs_data_reg, rs_data_next;
   logic [DATA_WIDTH-1:0]     rt_data_reg, rt_data_next;
   logic [DATA_WIDTH-1:0]     imm_reg, imm_next;
   logic [4:0]                rs_reg, rs_next;
   logic [4:0]                rt_reg, rt_next;
   logic [4:0]                rd_reg, rd_next;
   logic [4:0]                shamt_reg, shamt_next;
   logic                      valid_reg, valid_next;
   logic [CNT_WIDTH-1:0]      count_reg, count_next;

   logic [4:0]                id_rs, id_rt, id_rd, id_shamt;
   logic [DATA_WIDTH-1:0]     id_imm;
   logic                      zero_extend;
   logic                      load_in_ex;
   logic                      rt_match;
   logic                      load_bubble;
   logic                      count_inc;
   logic                      unused_opcode_bits;

   assign id_rs    = id_instruction[25:21];
   assign id_rt    = id_instruction[20:16];
   assign id_rd    = id_instruction[15:11];
   assign id_shamt = id_instruction[10:6];
   assign unused_opcode_bits = ^id_instruction[27:26];

   // Logical immediates (andi/ori/xori/lui) share the 4'b0011 opcode prefix.
   assign zero_extend = (id_instruction[31:28] == ZEXT_OPCODE_HI);
   assign id_imm = zero_extend
                 ? {{(DATA_WIDTH-16){1'b0}}, id_instruction[15:0]}
                 : {{(DATA_WIDTH-16){id_instruction[15]}}, id_instruction[15:0]};

   assign load_in_ex   = valid_reg & mem_reg[MEM_READ_BIT];
   assign rt_match     = (rt_reg == id_rs) | (rt_reg == id_rt);
   assign hazard_stall = load_in_ex & (rt_reg != 5'd0) & rt_match;

   assign load_bubble = flush | hazard_stall;
   assign pc_write    = enable & ~hazard_stall & ~flush;
   assign if_id_write = enable & ~hazard_stall & ~flush;

   // A flush is a squash, not a stall, so it never counts as a bubble.
   assign count_inc = hazard_stall & ~flush & ~(&count_reg);

   generate
      for (genvar gi = 0; gi < EXEC_BUS_WIDTH; gi++) begin : g_exec_gate
         assign exec_gated[gi] = id_execute_bus[gi] & ~load_bubble;
      end
      for (genvar gi = 0; gi < MEM_BUS_WIDTH; gi++) begin : g_mem_gate
         assign mem_gated[gi] = id_memory_bus[gi] & ~load_bubble;
      end
      for (genvar gi = 0; gi < WB_BUS_WIDTH; gi++) begin : g_wb_gate
         assign wb_gated[gi] = id_wb_bus[gi] & ~load_bubble;
      end
   endgenerate

   always_comb begin
      exec_next    = exec_reg;
      mem_next     = mem_reg;
      wb_next      = wb_reg;
      pc_next      = pc_reg;
      rs_data_next = rs_data_reg;
      rt_data_next = rt_data_reg;
      imm_next     = imm_reg;
      rs_next      = rs_reg;
      rt_next      = rt_reg;
      rd_next      = rd_reg;
      shamt_next   = shamt_reg;
      valid_next   = valid_reg;
      count_next   = count_reg;
      if (enable) begin
         // Data fields follow ID even on a bubble; only control is squashed.
         exec_next    = exec_gated;
         mem_next     = mem_gated;
         wb_next      = wb_gated;
         pc_next      = id_pc_next;
         rs_data_next = id_rs_data;
         rt_data_next = id_rt_data;
         imm_next     = id_imm;
         rs_next      = id_rs;
         rt_next      = id_rt;
         rd_next      = id_rd;
         shamt_next   = id_shamt;
         valid_next   = ~load_bubble;
         if (count_inc) begin
            count_next = count_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_reg    <= '0;
         mem_reg     <= '0;
         wb_reg      <= '0;
         pc_reg      <= '0;
         rs_data_reg <= '0;
         rt_data_reg <= '0;
         imm_reg     <= '0;
         rs_reg      <= '0;
         rt_reg      <= '0;
         rd_reg      <= '0;
         shamt_reg   <= '0;
         valid_reg   <= 1'b0;
         count_reg   <= '0;
      end else begin
         exec_reg    <= exec_next;
         mem_reg     <= mem_next;
         wb_reg      <= wb_next;
         pc_reg      <= pc_next;
         rs_data_reg <= rs_data_next;
         rt_data_reg <= rt_data_next;
         imm_reg     <= imm_next;
         rs_reg      <= rs_next;
         rt_reg      <= rt_next;
         rd_reg      <= rd_next;
         shamt_reg   <= shamt_next;
         valid_reg   <= valid_next;
         count_reg   <= count_next;
      end
   end

   assign ex_execute_bus = exec_reg;
   assign ex_memory_bus  = mem_reg;
   assign ex_wb_bus      = wb_reg;
   assign ex_pc_next     = pc_reg;
   assign ex_rs_data     = rs_data_reg;
   assign ex_rt_data     = rt_data_reg;
   assign ex_imm         = imm_reg;
   assign ex_rs          = rs_reg;
   assign ex_rt          = rt_reg;
   assign ex_rd          = rd_reg;
   assign ex_shamt       = shamt_reg;
   assign ex_valid       = valid_reg;
   assign bubble_count   = count_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: default instance plus a 2-bit counter
// instance sharing the same stimulus to exercise counter saturation.
module tb_id_ex_stage;

   localparam int EW = 7;
   localparam int MW = 3;
   localparam int WW = 2;
   localparam int DW = 32;
   localparam int PW = 32;
   localparam int CW = 16;

   localparam logic [31:0] ADDI_T1  = 32'h2109FFFC;
   localparam logic [31:0] ORI_T1   = 32'h3509FFFC;
   localparam logic [31:0] LW_T1    = 32'h8D090000;
   localparam logic [31:0] ADD_DEP  = 32'h01285020;
   localparam logic [31:0] LW_T2    = 32'h8D2A0000;
   localparam logic [31:0] ADD_T3   = 32'h01405820;
   localparam logic [31:0] LW_ZERO  = 32'h8C000000;
   localparam logic [31:0] ADD_ZERO = 32'h00004020;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enable = 1'b0;
   logic          flush = 1'b0;
   logic [EW-1:0] id_execute_bus = '0;
   logic [MW-1:0] id_memory_bus = '0;
   logic [WW-1:0] id_wb_bus = '0;
   logic [31:0]   id_instruction = '0;
   logic [PW-1:0] id_pc_next = '0;
   logic [DW-1:0] id_rs_data = '0;
   logic [DW-1:0] id_rt_data = '0;

   logic [EW-1:0] ex_execute_bus, ex_execute_bus_s;
   logic [MW-1:0] ex_memory_bus, ex_memory_bus_s;
   logic [WW-1:0] ex_wb_bus, ex_wb_bus_s;
   logic [PW-1:0] ex_pc_next, ex_pc_next_s;
   logic [DW-1:0] ex_rs_data, ex_rs_data_s, ex_rt_data, ex_rt_data_s;
   logic [DW-1:0] ex_imm, ex_imm_s;
   logic [4:0]    ex_rs, ex_rs_s, ex_rt, ex_rt_s, ex_rd, ex_rd_s;
   logic [4:0]    ex_shamt, ex_shamt_s;
   logic          ex_valid, ex_valid_s, hazard_stall, hazard_stall_s;
   logic          pc_write, pc_write_s, if_id_write, if_id_write_s;
   logic [CW-1:0] bubble_count;
   logic [1:0]    bubble_count_s;

   always #5 clk = ~clk;

   id_ex_stage #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
      .id_execute_bus(id_execute_bus), .id_memory_bus(id_memory_bus),
      .id_wb_bus(id_wb_bus), .id_instruction(id_instruction),
      .id_pc_next(id_pc_next), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .ex_execute_bus(ex_execute_bus), .ex_memory_bus(ex_memory_bus),
      .ex_wb_bus(ex_wb_bus), .ex_pc_next(ex_pc_next),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
      .ex_valid(ex_valid), .hazard_stall(hazard_stall), .pc_write(pc_write),
      .if_id_write(if_id_write), .bubble_count(bubble_count)
   );

   id_ex_stage #(.CNT_WIDTH(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
      .id_execute_bus(id_execute_bus), .id_memory_bus(id_memory_bus),
      .id_wb_bus(id_wb_bus), .id_instruction(id_instruction),
      .id_pc_next(id_pc_next), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .ex_execute_bus(ex_execute_bus_s), .ex_memory_bus(ex_memory_bus_s),
      .ex_wb_bus(ex_wb_bus_s), .ex_pc_next(ex_pc_next_s),
      .ex_rs_data(ex_rs_data_s), .ex_rt_data(ex_rt_data_s), .ex_imm(ex_imm_s),
      .ex_rs(ex_rs_s), .ex_rt(ex_rt_s), .ex_rd(ex_rd_s), .ex_shamt(ex_shamt_s),
      .ex_valid(ex_valid_s), .hazard_stall(hazard_stall_s), .pc_write(pc_write_s),
      .if_id_write(if_id_write_s), .bubble_count(bubble_count_s)
   );

   typedef struct {
      logic [EW-1:0] exec;
      logic [MW-1:0] mem;
      logic [WW-1:0] wb;
      logic [PW-1:0] pc;
      logic [DW-1:0] rs_data;
      logic [DW-1:0] rt_data;
      logic [DW-1:0] imm;
      logic [4:0]    rs;
      logic [4:0]    rt;
      logic [4:0]    rd;
      logic [4:0]    shamt;
      logic          valid;
      int            cnt;
      int            cnt_s;
   } ex_t;

   ex_t         m;
   ex_t         sb_q[$];
   int          tests_run = 0;
   int          failed = 0;
   logic [31:0] pc_ctr = 32'h0000_1004;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m.exec = '0; m.mem = '0; m.wb = '0; m.pc = '0;
      m.rs_data = '0; m.rt_data = '0; m.imm = '0;
      m.rs = '0; m.rt = '0; m.rd = '0; m.shamt = '0;
      m.valid = 1'b0; m.cnt = 0; m.cnt_s = 0;
   endtask

   task automatic compare_ex(input ex_t e, input string n);
      check({n, ":exec"},    ex_execute_bus, e.exec);
      check({n, ":mem"},     ex_memory_bus,  e.mem);
      check({n, ":wb"},      ex_wb_bus,      e.wb);
      check({n, ":pc"},      ex_pc_next,     e.pc);
      check({n, ":rs_data"}, ex_rs_data,     e.rs_data);
      check({n, ":rt_data"}, ex_rt_data,     e.rt_data);
      check({n, ":imm"},     ex_imm,         e.imm);
      check({n, ":rs"},      ex_rs,          e.rs);
      check({n, ":rt"},      ex_rt,          e.rt);
      check({n, ":rd"},      ex_rd,          e.rd);
      check({n, ":shamt"},   ex_shamt,       e.shamt);
      check({n, ":valid"},   ex_valid,       e.valid);
      check({n, ":count"},   bubble_count,   e.cnt);
      check({n, ":count_sat"}, bubble_count_s, e.cnt_s);
      check({n, ":valid_sat"}, ex_valid_s,   e.valid);
   endtask

   task automatic cycle(input string n, input logic en, input logic fl,
                        input logic [EW-1:0] ex, input logic [MW-1:0] mm,
                        input logic [WW-1:0] wb, input logic [31:0] instr);
      logic hz;
      logic bub;
      ex_t  e;
      @(negedge clk);
      enable = en; flush = fl;
      id_execute_bus = ex; id_memory_bus = mm; id_wb_bus = wb;
      id_instruction = instr;
      id_pc_next = pc_ctr;
      id_rs_data = $urandom;
      id_rt_data = $urandom;
      pc_ctr += 4;
      #1;
      hz = m.valid && m.mem[1] && (m.rt != 5'd0) &&
           ((m.rt == instr[25:21]) || (m.rt == instr[20:16]));
      check({n, ":hazard"},      hazard_stall,   hz);
      check({n, ":hazard_sat"},  hazard_stall_s, hz);
      check({n, ":pc_write"},    pc_write,       en && !hz && !fl);
      check({n, ":if_id_write"}, if_id_write,    en && !hz && !fl);
      if (en) begin
         bub = fl || hz;
         m.exec = bub ? '0 : ex;
         m.mem  = bub ? '0 : mm;
         m.wb   = bub ? '0 : wb;
         m.pc = id_pc_next; m.rs_data = id_rs_data; m.rt_data = id_rt_data;
         m.imm = (instr[31:28] == 4'b0011) ? {16'h0000, instr[15:0]}
                                           : {{16{instr[15]}}, instr[15:0]};
         m.rs = instr[25:21]; m.rt = instr[20:16];
         m.rd = instr[15:11]; m.shamt = instr[10:6];
         m.valid = !bub;
         if (!fl && hz) begin
            if (m.cnt < 65535) m.cnt++;
            if (m.cnt_s < 3) m.cnt_s++;
         end
      end
      sb_q.push_back(m);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      compare_ex(e, n);
      $display("[TB] %s en=%0b fl=%0b hz=%0b valid=%0b imm=%h cnt=%0d cnt_sat=%0d",
               n, en, fl, hz, ex_valid, ex_imm, bubble_count, bubble_count_s);
   endtask

   task automatic check_all_zero(input string n);
      check({n, ":exec"},   ex_execute_bus, 0);
      check({n, ":mem"},    ex_memory_bus,  0);
      check({n, ":wb"},     ex_wb_bus,      0);
      check({n, ":pc"},     ex_pc_next,     0);
      check({n, ":imm"},    ex_imm,         0);
      check({n, ":rt"},     ex_rt,          0);
      check({n, ":valid"},  ex_valid,       0);
      check({n, ":count"},  bubble_count,   0);
      check({n, ":count_sat"}, bubble_count_s, 0);
      check({n, ":hazard"}, hazard_stall,   0);
   endtask

   initial begin
      model_reset();
      #2 rst_n = 1'b0;
      #10;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      cycle("addi",      1, 0, 7'h15, 3'b000, 2'b10, ADDI_T1);
      cycle("ori",       1, 0, 7'h2A, 3'b000, 2'b10, ORI_T1);
      cycle("lw_t1",     1, 0, 7'h10, 3'b010, 2'b11, LW_T1);
      cycle("add_stall", 1, 0, 7'h22, 3'b000, 2'b10, ADD_DEP);
      cycle("add_go",    1, 0, 7'h22, 3'b000, 2'b10, ADD_DEP);
      cycle("lw_zero",   1, 0, 7'h10, 3'b010, 2'b11, LW_ZERO);
      cycle("use_zero",  1, 0, 7'h22, 3'b000, 2'b10, ADD_ZERO);
      cycle("addi_t1",   1, 0, 7'h15, 3'b000, 2'b10, ADDI_T1);
      cycle("use_nonld", 1, 0, 7'h22, 3'b000, 2'b10, ADD_DEP);
      cycle("lw_t1_f",   1, 0, 7'h10, 3'b010, 2'b11, LW_T1);
      cycle("flush_hz",  1, 1, 7'h22, 3'b000, 2'b10, ADD_DEP);
      cycle("lw_t1_z",   1, 0, 7'h10, 3'b010, 2'b11, LW_T1);
      for (int i = 0; i < 5; i++) begin
         cycle($sformatf("freeze%0d", i), 0, i[0], 7'(i), 3'b111, 2'b11, ADD_DEP ^ i);
      end
      for (int k = 0; k < 2; k++) begin
         cycle($sformatf("sat_lw1_%0d", k),  1, 0, 7'h10, 3'b010, 2'b11, LW_T1);
         cycle($sformatf("sat_lw2s_%0d", k), 1, 0, 7'h10, 3'b010, 2'b11, LW_T2);
         cycle($sformatf("sat_lw2_%0d", k),  1, 0, 7'h10, 3'b010, 2'b11, LW_T2);
         cycle($sformatf("sat_adds_%0d", k), 1, 0, 7'h22, 3'b000, 2'b10, ADD_T3);
         cycle($sformatf("sat_add_%0d", k),  1, 0, 7'h22, 3'b000, 2'b10, ADD_T3);
      end

      // Reset asserted mid-run with a load in EX and a dependent instruction in ID.
      cycle("lw_pre_rst", 1, 0, 7'h10, 3'b010, 2'b11, LW_T1);
      @(negedge clk);
      id_instruction = ADD_DEP;
      id_memory_bus = '0;
      #1;
      check("pre_rst:hazard", hazard_stall, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      check("async_rst:pc_write", pc_write, 1'b1);
      model_reset();
      @(negedge clk);
      check_all_zero("rst_held");
      rst_n = 1'b1;
      cycle("post_rst", 1, 0, 7'h22, 3'b000, 2'b10, ADD_DEP);

      for (int i = 0; i < 30; i++) begin
         logic [4:0]  regs[3];
         logic [31:0] instr;
         regs[0] = 5'd0; regs[1] = 5'd9; regs[2] = 5'd10;
         instr = $urandom;
         instr[25:21] = regs[$urandom_range(0, 2)];
         instr[20:16] = regs[$urandom_range(0, 2)];
         cycle($sformatf("rand%0d", i), ($urandom_range(0, 7) != 0),
               ($urandom_range(0, 5) == 0), 7'($urandom), 3'($urandom),
               2'($urandom), instr);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
